// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Brief    : Hack CPU data-memory decode (RAM / VRAM / keyboard) and VRAM
//            ownership arbitration between the CPU and video scanout.
// Revision : 1.0
// ============================================================================
module mem_arbiter #(
  parameter int DATA_WORDS   = 16384,
  parameter int GUARD_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] mem_address,
  input  logic        mem_load,
  input  logic [15:0] mem_wdata,
  output logic [15:0] mem_rdata,
  output logic        mem_busy,
  input  logic [15:0] kbd_code,
  input  logic        vid_req,
  input  logic [12:0] vid_addr,
  output logic        vid_grant,
  output logic [15:0] vid_rdata,
  output logic [12:0] vram_addr,
  output logic [15:0] vram_wdata,
  output logic        vram_we,
  input  logic [15:0] vram_rdata
);

  localparam int          c_AW         = (DATA_WORDS > 1) ? $clog2(DATA_WORDS) : 1;
  localparam int          c_GW         = $clog2(GUARD_CYCLES + 1);
  localparam logic [31:0] c_DEPTH      = 32'(DATA_WORDS);
  localparam logic [c_GW-1:0] c_GUARD_INIT = c_GW'(GUARD_CYCLES);
  localparam logic [15:0] c_KBD_ADDR   = 16'h6000;

  typedef enum logic [0:0] {
    CPU_OWN = 1'b0,
    VID_OWN = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    SEL_RAM  = 2'd0,
    SEL_VRAM = 2'd1,
    SEL_KBD  = 2'd2,
    SEL_NONE = 2'd3
  } sel_t;

  state_t          r_state;
  sel_t            r_sel;
  logic            r_vid_grant;
  logic            r_mem_busy;
  logic [c_GW-1:0] r_guard;
  logic [15:0]     r_prev_addr;
  logic [15:0]     r_ram_q;
  logic [15:0]     r_ram [0:DATA_WORDS-1];

  logic            w_is_ram;
  logic            w_is_vram;
  logic            w_is_kbd;
  logic            w_ram_hit;
  logic [c_AW-1:0] w_ram_idx;
  logic            w_addr_moved_vram;
  logic            w_guard_clear;
  logic            w_cpu_vram_wr;
  logic            w_grant_ok;

  assign w_is_ram  = !mem_address[14];
  assign w_is_vram = mem_address[14] && !mem_address[13];
  assign w_is_kbd  = (mem_address == c_KBD_ADDR);
  assign w_ram_idx = mem_address[c_AW-1:0];
  assign w_ram_hit = w_is_ram && ({18'd0, mem_address[13:0]} < c_DEPTH);

  // A fresh VRAM address counts as a non-zero guard so the grant cannot
  // slip in on the very edge the CPU arrives at a new VRAM word.
  assign w_addr_moved_vram = (mem_address != r_prev_addr) && w_is_vram;
  assign w_guard_clear     = (r_guard == '0) && !w_addr_moved_vram;
  assign w_cpu_vram_wr     = mem_load && w_is_vram;
  assign w_grant_ok        = vid_req && (!w_is_vram || w_guard_clear) && !w_cpu_vram_wr;

  always_ff @(posedge clk) begin
    if (mem_load && w_ram_hit) begin
      r_ram[w_ram_idx] <= mem_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ram_q <= '0;
      r_sel   <= SEL_RAM;
    end else begin
      r_ram_q <= w_ram_hit ? r_ram[w_ram_idx] : '0;
      if (w_is_ram) begin
        r_sel <= SEL_RAM;
      end else if (w_is_vram) begin
        r_sel <= SEL_VRAM;
      end else if (w_is_kbd) begin
        r_sel <= SEL_KBD;
      end else begin
        r_sel <= SEL_NONE;
      end
    end
  end

  always_comb begin
    mem_rdata = '0;
    case (r_sel)
      SEL_RAM:  mem_rdata = r_ram_q;
      SEL_VRAM: mem_rdata = vram_rdata;
      SEL_KBD:  mem_rdata = kbd_code;
      default:  mem_rdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= CPU_OWN;
      r_vid_grant <= 1'b0;
      r_mem_busy  <= 1'b0;
      r_guard     <= c_GUARD_INIT;
      r_prev_addr <= '0;
    end else begin
      r_prev_addr <= mem_address;
      case (r_state)
        CPU_OWN: begin
          if (w_addr_moved_vram) begin
            r_guard <= c_GUARD_INIT;
          end else if (r_guard != '0) begin
            r_guard <= r_guard - c_GW'(1);
          end
          if (w_grant_ok) begin
            r_state     <= VID_OWN;
            r_vid_grant <= 1'b1;
            r_mem_busy  <= 1'b1;
          end
        end
        VID_OWN: begin
          if (!vid_req) begin
            r_state     <= CPU_OWN;
            r_vid_grant <= 1'b0;
            r_mem_busy  <= 1'b0;
            r_guard     <= c_GUARD_INIT;
          end else if (w_addr_moved_vram) begin
            r_guard <= c_GUARD_INIT;
          end
        end
        default: begin
          r_state     <= CPU_OWN;
          r_vid_grant <= 1'b0;
          r_mem_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign mem_busy   = r_mem_busy;
  assign vid_grant  = r_vid_grant;
  assign vid_rdata  = vram_rdata;
  assign vram_wdata = mem_wdata;
  assign vram_addr  = (r_state == VID_OWN) ? vid_addr : mem_address[12:0];
  assign vram_we    = (r_state == CPU_OWN) && w_cpu_vram_wr && !r_mem_busy;

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Memory-map and VRAM arbitration stage directly downstream of the Hack CPU's data-memory port.
- Decodes the CPU's 16-bit A-addressed accesses into three regions: internal data RAM (0x0000-0x3FFF), shared VRAM (0x4000-0x5FFF) and the keyboard register (0x6000).
- Arbitrates the single VRAM port between the CPU and the video scanout engine.
- Drives mem_busy so the CPU's VRAM wait protocol (wait for busy low, then 2 extra cycles) is always honoured.

Parameters:
- DATA_WORDS, 16384, depth of the inferred internal data RAM; addresses at or above this read 0.
- GUARD_CYCLES, 4, CPU-priority window length after VRAM ownership returns to the CPU; must be ≥3.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- mem_address  in  16  CPU data address (A register).
- mem_load  in  1  CPU write strobe; may be held high across stalled cycles.
- mem_wdata  in  16  CPU write data.
- mem_rdata  out  16  registered read data to the CPU.
- mem_busy  out  1  registered; high while video owns VRAM.
- kbd_code  in  16  current keyboard scancode.
- vid_req  in  1  level request from scanout for VRAM ownership.
- vid_addr  in  13  scanout VRAM word address.
- vid_grant  out  1  registered; video owns VRAM.
- vid_rdata  out  16  VRAM read data to scanout, valid 1 cycle after vid_addr.
- vram_addr  out  13  VRAM block RAM address.
- vram_wdata  out  16  VRAM write data.
- vram_we  out  1  VRAM write enable.
- vram_rdata  in  16  VRAM block RAM read data, 1-cycle registered latency.

Behaviour:
- Reset values:
  - mem_rdata = 0, mem_busy = 0, vid_grant = 0.
  - guard counter = GUARD_CYCLES; previous-address register = 0; region select = RAM.
  - RAM contents are not cleared.
- Region decode:
  - ram = !a[14].
  - vram = a[14] && !a[13].
  - kbd = (a == 0x6000).
  - All other addresses are "none": reads return 0, writes are dropped.
- Read path:
  - Each edge registers the RAM word at a[13:0] and the region select.
  - mem_rdata = RAM word, vram_rdata, kbd_code or 0, according to the registered select.
  - Fast regions are therefore valid 1 cycle after mem_address changes.
  - VRAM reads are valid 1 cycle after vram_addr carries the CPU address.
- Writes:
  - RAM: mem_load && ram commits mem_wdata at the edge.
  - VRAM: mem_load && vram && !mem_busy drives vram_we = 1 with vram_addr = a[12:0]. vram_we is never asserted while vid_grant = 1.
  - Keyboard and "none" writes are ignored.
- State machine: CPU_OWN and VID_OWN.
  - CPU_OWN: vram_addr = mem_address[12:0].
    - Go to VID_OWN when vid_req && (!vram || guard == 0) && !(mem_load && vram).
    - The transition sets vid_grant = 1 and mem_busy = 1 at the same edge.
    - A coincident CPU VRAM write takes priority and delays the grant by one cycle.
  - VID_OWN: vram_addr = vid_addr and vram_we = 0.
    - When vid_req = 0, return to CPU_OWN: clear vid_grant and mem_busy, and reload guard = GUARD_CYCLES.
- Guard counter:
  - Decrements to 0 in CPU_OWN.
  - Reloads to GUARD_CYCLES on any edge where mem_address differs from the previous-address register and the new address is in vram.
  - This guarantees the 3-cycle CPU read window after it samples mem_busy low.
- Video sees no data contract outside vid_grant; vid_rdata during CPU_OWN is don't-care.
- Reset mid-burst: forces CPU_OWN immediately. The scanout must re-request.

Test Plan:
- RAM round trip: write 0x1234 to 0x0010 with mem_load for 1 cycle, then set address 0x0010 → mem_rdata = 0x1234 one cycle after the address changes.
- Keyboard and unmapped: kbd_code = 0x0041, read 0x6000 → 0x0041; write 0x6000 → no effect; read 0x7000 → 0x0000.
- Video burst: vid_req high for 8 cycles with vid_addr 0..7 (VRAM preloaded) → vid_grant and mem_busy rise the next edge; vid_rdata tracks VRAM words with 1-cycle lag; both flags fall 1 edge after vid_req drops.
- Stalled CPU VRAM write: mem_load held with address 0x4005 and data 0xBEEF during a burst → vram_we stays 0 until mem_busy = 0, then pulses exactly once; 0x4005 reads 0xBEEF.
- Guard window: CPU address changes to 0x4100 while vid_req = 1 → no grant for GUARD_CYCLES cycles; CPU read of 0x4100 returns the correct data; grant follows.
- Contention: simultaneous vid_req rise and CPU VRAM write → write commits first, grant one cycle later; reset asserted mid-burst → vid_grant = 0 and mem_busy = 0 on the next edge.
